// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS instruction-fetch slice.
package mips_pkg;

    localparam int          IMEM_DEPTH_DEFAULT = 32;
    localparam logic [31:0] NOP_WORD           = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD_DEFAULT  = 32'hFFFF_FFFF;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int FUNCT_HI  = 5;
    localparam int FUNCT_LO  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/imem_32x32.sv
// Loadable instruction memory: synchronous write port, combinational read port, no reset.
module imem_32x32
    import mips_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH_DEFAULT,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [DEPTH];

    // Program load port; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, instruction memory, IF/ID register and IDLE/RUN/HALT control.
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter int            IMEM_DEPTH = IMEM_DEPTH_DEFAULT,
    parameter logic [31:0]   HALT_WORD  = HALT_WORD_DEFAULT,
    localparam int           PC_W       = $clog2(IMEM_DEPTH),
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            load_we,
    input  logic [PC_W-1:0] load_addr,
    input  logic [31:0]     load_data,
    input  logic            stall,
    input  logic            flush,
    input  logic            redirect_en,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [31:0]     if_id_out_instruccion,
    output logic [PC_W-1:0] if_id_out_PC_next,
    output logic [5:0]      if_id_out_opcode,
    output logic [5:0]      if_id_out_funct,
    output logic            if_id_valid,
    output logic [PC_W-1:0] PC_toFetch_out,
    output logic            halted
);

    // A bubble clears the whole IF/ID register: word, PC+1 and valid.
    localparam logic [32+PC_W:0] IF_ID_NOP = {NOP_WORD, {PC_W{1'b0}}, 1'b0};

    fetch_state_t    state_r;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] pc_inc_s;
    logic [PC_W-1:0] pc_next_r;
    logic [31:0]     instr_r;
    logic [31:0]     fetch_word_s;
    logic            valid_r;
    logic            halted_r;
    logic            imem_we_s;

    assign pc_inc_s  = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
    assign imem_we_s = reset && load_we && (state_r == IDLE);

    imem_32x32 #(
        .DEPTH (IMEM_DEPTH)
    ) u_imem (
        .clk   (clk),
        .we    (imem_we_s),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (pc_r),
        .rdata (fetch_word_s)
    );

    // Control FSM, PC and IF/ID register; redirect beats stall, stall beats flush.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r                         <= IDLE;
            pc_r                            <= RESET_PC;
            {instr_r, pc_next_r, valid_r}   <= IF_ID_NOP;
            halted_r                        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    {instr_r, pc_next_r, valid_r} <= IF_ID_NOP;
                    halted_r                      <= 1'b0;
                    if (start) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    halted_r <= 1'b0;
                    if (redirect_en) begin
                        pc_r                          <= redirect_pc;
                        {instr_r, pc_next_r, valid_r} <= IF_ID_NOP;
                    end else if (stall) begin
                        if (flush) begin
                            {instr_r, pc_next_r, valid_r} <= IF_ID_NOP;
                        end else begin
                            {instr_r, pc_next_r, valid_r} <= {instr_r, pc_next_r, valid_r};
                        end
                    end else if (flush) begin
                        pc_r                          <= pc_inc_s;
                        {instr_r, pc_next_r, valid_r} <= IF_ID_NOP;
                    end else if (fetch_word_s == HALT_WORD) begin
                        // The halt marker is never issued downstream and the PC stays on it.
                        {instr_r, pc_next_r, valid_r} <= IF_ID_NOP;
                        halted_r                      <= 1'b1;
                        state_r                       <= HALT;
                    end else begin
                        pc_r      <= pc_inc_s;
                        instr_r   <= fetch_word_s;
                        pc_next_r <= pc_inc_s;
                        valid_r   <= 1'b1;
                    end
                end
                HALT: begin
                    {instr_r, pc_next_r, valid_r} <= IF_ID_NOP;
                    halted_r                      <= 1'b1;
                end
                default: begin
                    state_r                       <= IDLE;
                    {instr_r, pc_next_r, valid_r} <= IF_ID_NOP;
                    halted_r                      <= 1'b0;
                end
            endcase
        end
    end

    assign if_id_out_instruccion = instr_r;
    assign if_id_out_PC_next     = pc_next_r;
    assign if_id_out_opcode      = instr_r[OPCODE_HI:OPCODE_LO];
    assign if_id_out_funct       = instr_r[FUNCT_HI:FUNCT_LO];
    assign if_id_valid           = valid_r;
    assign PC_toFetch_out        = pc_r;
    assign halted                = halted_r;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        load_we;
    logic [4:0]  load_addr;
    logic [31:0] load_data;
    logic        stall;
    logic        flush;
    logic        redirect_en;
    logic [4:0]  redirect_pc;
    logic [31:0] if_id_out_instruccion;
    logic [4:0]  if_id_out_PC_next;
    logic [5:0]  if_id_out_opcode;
    logic [5:0]  if_id_out_funct;
    logic        if_id_valid;
    logic [4:0]  PC_toFetch_out;
    logic        halted;

    int errors = 0;
    int checks = 0;

    // Behavioural model: memory image, PC as an integer, run/halt flags, expected IF/ID contents.
    logic [31:0] m_mem [32];
    int          m_pc;
    bit          m_running;
    bit          m_halted;
    logic [31:0] m_instr;
    int          m_pcn;
    bit          m_valid;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk                   (clk),
        .reset                 (reset),
        .start                 (start),
        .load_we               (load_we),
        .load_addr             (load_addr),
        .load_data             (load_data),
        .stall                 (stall),
        .flush                 (flush),
        .redirect_en           (redirect_en),
        .redirect_pc           (redirect_pc),
        .if_id_out_instruccion (if_id_out_instruccion),
        .if_id_out_PC_next     (if_id_out_PC_next),
        .if_id_out_opcode      (if_id_out_opcode),
        .if_id_out_funct       (if_id_out_funct),
        .if_id_valid           (if_id_valid),
        .PC_toFetch_out        (PC_toFetch_out),
        .halted                (halted)
    );

    function automatic void model_bubble();
        m_instr = 32'h0000_0000;
        m_pcn   = 0;
        m_valid = 1'b0;
    endfunction

    // One clock of architectural behaviour, evaluated from the inputs present before the edge.
    function automatic void model_step();
        if (!reset) begin
            m_pc      = 0;
            m_running = 1'b0;
            m_halted  = 1'b0;
            model_bubble();
        end else if (m_halted) begin
            model_bubble();
        end else if (!m_running) begin
            if (load_we) m_mem[load_addr] = load_data;
            model_bubble();
            if (start) m_running = 1'b1;
        end else if (redirect_en) begin
            m_pc = int'(redirect_pc);
            model_bubble();
        end else if (stall) begin
            if (flush) model_bubble();
        end else if (flush) begin
            m_pc = (m_pc + 1) % 32;
            model_bubble();
        end else if (m_mem[m_pc] == 32'hFFFF_FFFF) begin
            model_bubble();
            m_running = 1'b0;
            m_halted  = 1'b1;
        end else begin
            m_instr = m_mem[m_pc];
            m_pcn   = (m_pc + 1) % 32;
            m_valid = 1'b1;
            m_pc    = (m_pc + 1) % 32;
        end
    endfunction

    function automatic logic [55:0] dut_vec();
        return {if_id_out_instruccion, (m_valid ? if_id_out_PC_next : 5'd0), if_id_out_opcode,
                if_id_out_funct, if_id_valid, PC_toFetch_out, halted};
    endfunction

    function automatic logic [55:0] model_vec();
        logic [31:0] w;
        w = m_instr;
        return {w, (m_valid ? 5'(m_pcn) : 5'd0), w[31:26], w[5:0], m_valid, 5'(m_pc), m_halted};
    endfunction

    function automatic logic [31:0] rand_nonhalt();
        logic [31:0] v;
        v = $urandom;
        if (v == 32'hFFFF_FFFF) v = 32'h0000_0001;
        return v;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start       = 1'b0;
        load_we     = 1'b0;
        load_addr   = 5'd0;
        load_data   = 32'h0000_0000;
        stall       = 1'b0;
        flush       = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 5'd0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic load_word(input logic [4:0] a, input logic [31:0] d);
        load_we   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_we   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic redirect_to(input logic [4:0] target);
        redirect_en = 1'b1;
        redirect_pc = target;
        tick();
        redirect_en = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (PC_toFetch_out !== 5'd0) begin
            errors++;
            $display("FAIL reset_pc got=%0d exp=0", PC_toFetch_out);
        end
        checks++;
        if (if_id_valid !== 1'b0 || if_id_out_instruccion !== 32'h0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_ifid got valid=%b instr=%h halted=%b exp 0/0/0",
                     if_id_valid, if_id_out_instruccion, halted);
        end
        reset = 1'b1;
    endtask

    task automatic test_program_halt();
        logic [31:0] exp_i [3];
        exp_i = '{32'h20010fff, 32'h00214020, 32'h34030006};
        apply_reset();
        load_word(5'd0, 32'h20010fff);
        load_word(5'd1, 32'h00214020);
        load_word(5'd2, 32'h34030006);
        load_word(5'd3, 32'hFFFF_FFFF);
        for (int a = 4; a < 32; a++) load_word(5'(a), rand_nonhalt());
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (if_id_out_instruccion !== exp_i[k] || if_id_out_PC_next !== 5'(k + 1) || if_id_valid !== 1'b1) begin
                errors++;
                $display("FAIL prog_fetch k=%0d got instr=%h pcn=%0d v=%b exp instr=%h pcn=%0d v=1",
                         k, if_id_out_instruccion, if_id_out_PC_next, if_id_valid, exp_i[k], k + 1);
            end
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL prog_model k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
        end
        tick();
        checks++;
        if (halted !== 1'b1 || PC_toFetch_out !== 5'd3 || if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL prog_halt got halted=%b pc=%0d v=%b exp 1/3/0", halted, PC_toFetch_out, if_id_valid);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (halted !== 1'b1 || PC_toFetch_out !== 5'd3 || dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL halt_sticky got=%h exp=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_mid_run_reset();
        apply_reset();
        pulse_start();
        redirect_to(5'd5);
        tick();
        tick();
        checks++;
        if (PC_toFetch_out !== 5'd7) begin
            errors++;
            $display("FAIL midreset_pre got pc=%0d exp=7", PC_toFetch_out);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (PC_toFetch_out !== 5'd0 || if_id_valid !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle got pc=%0d v=%b halted=%b exp 0/0/0", PC_toFetch_out, if_id_valid, halted);
        end
        pulse_start();
        tick();
        checks++;
        if (if_id_out_instruccion !== 32'h20010fff || if_id_out_PC_next !== 5'd1) begin
            errors++;
            $display("FAIL midreset_rerun0 got instr=%h pcn=%0d exp 20010fff/1", if_id_out_instruccion, if_id_out_PC_next);
        end
        tick();
        tick();
        checks++;
        if (if_id_out_instruccion !== 32'h34030006 || if_id_out_PC_next !== 5'd3) begin
            errors++;
            $display("FAIL midreset_rerun2 got instr=%h pcn=%0d exp 34030006/3", if_id_out_instruccion, if_id_out_PC_next);
        end
        tick();
        checks++;
        if (halted !== 1'b1 || PC_toFetch_out !== 5'd3 || dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL midreset_rehalt got=%h exp=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_stall();
        apply_reset();
        pulse_start();
        tick();
        tick();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (PC_toFetch_out !== 5'd2 || if_id_out_instruccion !== 32'h00214020 ||
                if_id_out_PC_next !== 5'd2 || if_id_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold k=%0d got pc=%0d instr=%h pcn=%0d v=%b exp 2/00214020/2/1",
                         k, PC_toFetch_out, if_id_out_instruccion, if_id_out_PC_next, if_id_valid);
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if (if_id_out_instruccion !== 32'h34030006 || if_id_out_PC_next !== 5'd3 || PC_toFetch_out !== 5'd3) begin
            errors++;
            $display("FAIL stall_resume got instr=%h pcn=%0d pc=%0d exp 34030006/3/3",
                     if_id_out_instruccion, if_id_out_PC_next, PC_toFetch_out);
        end
    endtask

    task automatic test_redirect_stall();
        logic [31:0] w3;
        w3 = rand_nonhalt();
        apply_reset();
        load_word(5'd3, w3);
        pulse_start();
        redirect_to(5'd4);
        stall = 1'b1;
        flush = 1'b1;
        redirect_to(5'd3);
        stall = 1'b0;
        flush = 1'b0;
        checks++;
        if (PC_toFetch_out !== 5'd3 || if_id_out_instruccion !== 32'h0 || if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_over_stall got pc=%0d instr=%h v=%b exp 3/0/0",
                     PC_toFetch_out, if_id_out_instruccion, if_id_valid);
        end
        tick();
        checks++;
        if (if_id_out_instruccion !== w3 || if_id_out_PC_next !== 5'd4 || if_id_valid !== 1'b1) begin
            errors++;
            $display("FAIL redir_fetch got instr=%h pcn=%0d v=%b exp %h/4/1",
                     if_id_out_instruccion, if_id_out_PC_next, if_id_valid, w3);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        pulse_start();
        redirect_to(5'd30);
        tick();
        tick();
        checks++;
        if (if_id_out_instruccion !== m_mem[31] || if_id_out_PC_next !== 5'd0 || PC_toFetch_out !== 5'd0) begin
            errors++;
            $display("FAIL wrap got instr=%h pcn=%0d pc=%0d exp %h/0/0",
                     if_id_out_instruccion, if_id_out_PC_next, PC_toFetch_out, m_mem[31]);
        end
        tick();
        checks++;
        if (if_id_out_instruccion !== 32'h20010fff || PC_toFetch_out !== 5'd1 || dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL wrap_next got=%h exp=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_load_in_run();
        apply_reset();
        pulse_start();
        tick();
        load_we   = 1'b1;
        load_addr = 5'd0;
        load_data = 32'h0000_0000;
        tick();
        load_we   = 1'b0;
        redirect_to(5'd0);
        tick();
        checks++;
        if (if_id_out_instruccion !== 32'h20010fff || if_id_out_PC_next !== 5'd1 || if_id_valid !== 1'b1) begin
            errors++;
            $display("FAIL run_load_ignored got instr=%h pcn=%0d v=%b exp 20010fff/1/1",
                     if_id_out_instruccion, if_id_out_PC_next, if_id_valid);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            apply_reset();
            for (int k = 0; k < 3; k++)
                load_word(5'($urandom_range(0, 31)), ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : rand_nonhalt());
            pulse_start();
            for (int c = 0; c < 120; c++) begin
                reset       = ($urandom_range(0, 63) != 0);
                start       = ($urandom_range(0, 15) == 0);
                load_we     = ($urandom_range(0, 3) == 0);
                load_addr   = 5'($urandom);
                load_data   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : rand_nonhalt();
                stall       = ($urandom_range(0, 3) == 0);
                flush       = ($urandom_range(0, 4) == 0);
                redirect_en = ($urandom_range(0, 7) == 0);
                redirect_pc = 5'($urandom);
                tick();
                checks++;
                if (dut_vec() !== model_vec()) begin
                    errors++;
                    $display("FAIL random r=%0d c=%0d got=%h exp=%h", r, c, dut_vec(), model_vec());
                end
            end
            reset = 1'b1;
            idle_inputs();
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_program_halt();
        test_mid_run_reset();
        test_stall();
        test_redirect_stall();
        test_wrap();
        test_load_in_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
